// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VRAM port-B prefetcher, 1-bpp serialiser and raster timing generator
module vram_scanout #(
    parameter int          H_ACTIVE  = 768,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 64,
    parameter int          H_BP      = 80,
    parameter int          V_ACTIVE  = 896,
    parameter int          V_FP      = 2,
    parameter int          V_SYNC    = 4,
    parameter int          V_BP      = 26,
    parameter logic [14:0] BASE_ADDR = 15'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic        enable,
    input  logic        invert,
    output logic [14:0] vram_addr,
    output logic        vram_rden,
    input  logic [31:0] vram_q,
    output logic        video,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start,
    output logic        underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int WPL     = H_ACTIVE / 32;
    localparam int PW      = $clog2(WPL + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ARM_MAX = VW'(V_ACTIVE - 2);

    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

    state_t          state, state_n;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [31:0]     buf0, buf1, shift, word;
    logic [1:0]      count;
    logic [PW-1:0]   pending;
    logic            fetch_ok, armed;
    logic            active, hs_on, vs_on, vsync_start, rearm, flush;
    logic            ld, have, push, pop, start;

    assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_on       = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_on       = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign vsync_start = pix_ce && (hcnt == '0) && (vcnt == VS_BEG);
    assign rearm       = pix_ce && (hcnt == H_ACT) && ((vcnt == V_LAST) || (vcnt <= V_ARM_MAX));
    assign flush       = !enable || vsync_start;

    // A load from an empty (or flushed) buffer feeds zeros into the serialiser.
    assign ld    = pix_ce && active && (hcnt[4:0] == 5'd0);
    assign have  = armed && enable && (count != 2'd0);
    assign word  = have ? buf0 : '0;
    assign pop   = ld && have;
    assign push  = (state == CAPT) && !flush;
    assign start = (state == IDLE) && (state_n == REQ);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (enable && fetch_ok && !vsync_start && (pending != '0) && (count != 2'd2))
                      state_n = REQ;
            REQ:  state_n = CAPT;
            CAPT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            vram_rden <= 1'b0;
            vram_addr <= BASE_ADDR;
            pending   <= '0;
            fetch_ok  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            vram_rden <= (state_n == REQ);
            if (vsync_start)
                vram_addr <= BASE_ADDR;
            else if (state == REQ)
                vram_addr <= vram_addr + 15'd1;
            if (flush)
                pending <= '0;
            else if (rearm)
                pending <= start ? PW'(WPL - 1) : PW'(WPL);
            else if (start)
                pending <= pending - PW'(1);
            // Fetching only restarts from a known address, i.e. at vsync.
            if (vsync_start)
                fetch_ok <= enable;
            else if (!enable)
                fetch_ok <= 1'b0;
            if (vsync_start && enable)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf0  <= '0;
            buf1  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= vram_q;
                    else               buf1 <= vram_q;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= vram_q;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= vram_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift       <= '0;
            video       <= 1'b0;
            blank       <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= pix_ce && (hcnt == '0) && (vcnt == '0);
            if (ld && armed && enable && (count == 2'd0))
                underrun <= 1'b1;
            if (pix_ce) begin
                if (active)
                    shift <= ld ? {1'b0, word[31:1]} : {1'b0, shift[31:1]};
                video <= enable && active && ((ld ? word[0] : shift[0]) ^ invert);
                blank <= !(enable && active);
                hsync <= !(enable && hs_on);
                vsync <= !(enable && vs_on);
            end
        end
    end

endmodule
